// File: rtl/sr_latch_monitor_pkg.sv
// Shared types and constants for the SR latch monitor.
package sr_latch_monitor_pkg;

    typedef enum logic [1:0] {
        ST_UNKNOWN  = 2'd0,
        ST_SETTLING = 2'd1,
        ST_STABLE   = 2'd2
    } mon_state_e;

    localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/sr_latch_monitor_sync2.sv
// Two-flop synchronizer for the asynchronous latch outputs.
module sync2
    import sr_latch_monitor_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] stages;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = stages[SYNC_DEPTH-1];

endmodule

// File: rtl/sr_latch_monitor.sv
// Tracks the expected state of an external SR latch and flags
// disagreements, illegal requests and illegal output combinations.
module sr_latch_monitor
    import sr_latch_monitor_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             set,
    input  logic             reset,
    input  logic             q,
    input  logic             qbar,
    output logic             expected_q,
    output logic             busy,
    output logic             mismatch,
    output logic             illegal_in,
    output logic             illegal_out,
    output logic [CNT_W-1:0] set_count,
    output logic [CNT_W-1:0] reset_count
);

    localparam int unsigned      WIN_W    = $clog2(SETTLE_CYCLES + 3);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(SETTLE_CYCLES + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    mon_state_e       state;
    logic [WIN_W-1:0] window;
    logic [WIN_W-1:0] exempt;
    logic             qs;
    logic             qbs;
    logic             set_d;
    logic             reset_d;

    logic both_c;
    logic valid_c;
    logic match_c;
    logic new_tgt_c;
    logic expired_c;
    logic mismatch_ev_c;
    logic illegal_out_ev_c;

    sync2 u_sync_q (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (q),
        .q       (qs)
    );

    sync2 u_sync_qbar (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (qbar),
        .q       (qbs)
    );

    // Request decode and comparisons against the synchronized latch outputs.
    assign both_c    = set & reset;
    assign valid_c   = set ^ reset;
    assign match_c   = (qs == expected_q) && (qbs == ~expected_q);
    assign new_tgt_c = valid_c && (set != expected_q);
    assign expired_c = (window == WIN_W'(1));

    assign mismatch_ev_c = enable &&
        (((state == ST_STABLE) && !match_c) ||
         ((state == ST_SETTLING) && !new_tgt_c && !match_c && expired_c));

    assign illegal_out_ev_c = enable && (state != ST_UNKNOWN) && (qs == qbs) &&
                              !both_c && (exempt == '0);

    // Latch model FSM; busy is registered alongside the state it reflects.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_UNKNOWN;
            window     <= '0;
            expected_q <= 1'b0;
            busy       <= 1'b0;
        end else if (!enable || both_c) begin
            state <= ST_UNKNOWN;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                ST_UNKNOWN: begin
                    if (valid_c) begin
                        expected_q <= set;
                        window     <= WIN_LOAD;
                        state      <= ST_SETTLING;
                        busy       <= 1'b1;
                    end
                end
                ST_SETTLING: begin
                    if (new_tgt_c) begin
                        expected_q <= set;
                        window     <= WIN_LOAD;
                    end else if (match_c || expired_c) begin
                        state <= ST_STABLE;
                        busy  <= 1'b0;
                    end else begin
                        window <= window - WIN_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (new_tgt_c) begin
                        expected_q <= set;
                        window     <= WIN_LOAD;
                        state      <= ST_SETTLING;
                        busy       <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_UNKNOWN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Edge detect and the post-illegal-request grace period for illegal_out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            set_d   <= 1'b0;
            reset_d <= 1'b0;
            exempt  <= '0;
        end else begin
            set_d   <= set;
            reset_d <= reset;
            if (both_c) begin
                exempt <= WIN_LOAD;
            end else if (exempt != '0) begin
                exempt <= exempt - WIN_W'(1);
            end
        end
    end

    // Sticky flags and saturating counters; clear wins over same-cycle events.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mismatch    <= 1'b0;
            illegal_in  <= 1'b0;
            illegal_out <= 1'b0;
            set_count   <= '0;
            reset_count <= '0;
        end else if (clear) begin
            mismatch    <= 1'b0;
            illegal_in  <= 1'b0;
            illegal_out <= 1'b0;
            set_count   <= '0;
            reset_count <= '0;
        end else if (enable) begin
            if (mismatch_ev_c) begin
                mismatch <= 1'b1;
            end
            if (both_c) begin
                illegal_in <= 1'b1;
            end
            if (illegal_out_ev_c) begin
                illegal_out <= 1'b1;
            end
            if (set && !set_d && (set_count != CNT_MAX)) begin
                set_count <= set_count + CNT_W'(1);
            end
            if (reset && !reset_d && (reset_count != CNT_MAX)) begin
                reset_count <= reset_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/sr_latch_monitor.md
SR_LATCH_MONITOR -- requirements
Module: sr_latch_monitor

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, the allowed latch response time in clock cycles, excluding synchronizer delay.
REQ-002 The block SHALL have parameter CNT_W, default 8, the width of the event counters.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-004 clock  in  1  rising-edge clock for all state.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  checking enabled when 1.
REQ-007 clear  in  1  synchronous clear of sticky flags and counters.
REQ-008 set  in  1  active-high set request driven to the latch, synchronous to clock.
REQ-009 reset  in  1  active-high reset request driven to the latch, synchronous to clock.
REQ-010 q  in  1  latch Q output, asynchronous.
REQ-011 qbar  in  1  latch Qbar output, asynchronous.
REQ-012 expected_q  out  1  modelled latch state.
REQ-013 busy  out  1  high while in SETTLING.
REQ-014 mismatch  out  1  sticky flag for a latch output that disagrees with the model.
REQ-015 illegal_in  out  1  sticky flag for set and reset both asserted.
REQ-016 illegal_out  out  1  sticky flag for synced q equal to synced qbar outside the exempt cases.
REQ-017 set_count  out  CNT_W  count of set rising edges, saturating.
REQ-018 reset_count  out  CNT_W  count of reset rising edges, saturating.

Function
REQ-019 q and qbar SHALL each pass through a 2-flop synchronizer (qs, qbs) before any comparison, giving 2 cycles of latency.
REQ-020 The FSM SHALL have exactly three states: UNKNOWN, SETTLING and STABLE.
REQ-021 Request decode SHALL be: set&~reset gives target 1; reset&~set gives target 0; neither holds the state; both is illegal.
REQ-022 From UNKNOWN, a valid set or reset request SHALL load expected_q with the target and enter SETTLING with window = SETTLE_CYCLES+2.
REQ-023 In STABLE, a valid request whose target differs from expected_q SHALL load expected_q and enter SETTLING; a request whose target equals expected_q SHALL stay in STABLE.
REQ-024 In SETTLING, a valid request with a new target SHALL reload expected_q and restart the window.
REQ-025 In SETTLING, qs==expected_q and qbs==~expected_q SHALL move the FSM to STABLE on the next edge.
REQ-026 In SETTLING, window expiry without a match SHALL set mismatch and move the FSM to STABLE.
REQ-027 In STABLE, any cycle with qs!=expected_q or qbs!=~expected_q SHALL set mismatch.
REQ-028 In any state, set&reset SHALL set illegal_in and move the FSM to UNKNOWN; expected_q holds its last value.
REQ-029 illegal_out SHALL be set when qs==qbs, except in UNKNOWN and except within SETTLE_CYCLES+2 cycles after set&reset is deasserted.
REQ-030 No mismatch check SHALL occur in UNKNOWN.
REQ-031 enable=0 SHALL force the FSM to UNKNOWN, suppress all flag setting, and hold both counters.
REQ-032 Counters SHALL increment on input rising edge (input & ~previous) while enable=1, including edges during set&reset, and SHALL saturate at 2^CNT_W-1.
REQ-033 clear SHALL zero all flags and counters on the next edge, SHALL take priority over a same-cycle flag or count event (the event is lost), and SHALL NOT change FSM state or expected_q.
REQ-034 Flags SHALL stay set until clear or reset_n.

Reset
REQ-035 reset_n=0 SHALL asynchronously force: FSM UNKNOWN, expected_q 0, busy 0, all flags 0, counters 0, synchronizer and edge-detect flops 0.
REQ-036 Deassertion of reset_n SHALL take effect at the first clock edge after release, with no further initialization cycles.
REQ-037 reset_n asserted during SETTLING SHALL discard the window, and no mismatch SHALL be reported for that window.

Structure
REQ-038 A shared package SHALL hold the FSM state enum (UNKNOWN, SETTLING, STABLE) and the synchronizer depth constant (2).
REQ-039 The 2-flop synchronizer SHALL be a separate sub-module, sync2, instantiated once each for q and qbar.
REQ-040 Window counter width SHALL be $clog2(SETTLE_CYCLES+3).

Verification
REQ-041 Reset, then reset=1 for 5 cycles with the model latch -> expected_q=0, busy for at most 4 cycles, STABLE, reset_count=1, no flags.
REQ-042 reset pulse then set=1 with the model latch -> expected_q=1, STABLE within 4 cycles, set_count=1, mismatch=0.
REQ-043 set=1 with q held at 0 -> mismatch=1 exactly 4 cycles after SETTLING entry.
REQ-044 set=reset=1 for 3 cycles -> illegal_in=1, FSM UNKNOWN, illegal_out stays 0; then set alone -> recovery to STABLE with expected_q=1.
REQ-045 CNT_W=2, 5 set pulses -> set_count=3; clear in the same cycle as a 6th edge -> set_count=0.
REQ-046 reset_n asserted mid-SETTLING -> all outputs 0 immediately, no mismatch after release.
